// File: rtl/return_stack_ctrl_pkg.sv
// Shared definitions for the return-stack controller: op encodings, FSM states, defaults.
package rstack_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_W   = 7;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_REPLACE = 2'd2,
        OP_POP     = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/return_stack_ctrl_if.sv
// Bus between the requesters, the controller and the return_stack storage.
interface return_stack_ctrl_if #(
    parameter int WIDTH = rstack_pkg::WIDTH_DEF
);
    // Handshake: a port presents req=1 with a non-zero op and holds it until gnt;
    // gnt marks the single issue cycle, done follows one cycle later with rdata valid.
    logic                           req0, req1;
    logic [1:0]                     op0, op1;
    logic [WIDTH-1:0]               w0, w1;
    logic                           gnt0, gnt1, done0, done1;
    logic [WIDTH-1:0]               rdata;
    logic                           flush, flush_done;
    logic [1:0]                     stackOP;
    logic [WIDTH-1:0]               w, a, b;
    logic [rstack_pkg::DEPTH_W-1:0] depth;
    logic                           ovf, unf;

    modport master (
        output req0, req1, op0, op1, w0, w1, flush, a, b,
        input  gnt0, gnt1, done0, done1, rdata, flush_done, stackOP, w, depth, ovf, unf
    );

    modport slave (
        input  req0, req1, op0, op1, w0, w1, flush, a, b,
        output gnt0, gnt1, done0, done1, rdata, flush_done, stackOP, w, depth, ovf, unf
    );

endinterface

// File: rtl/return_stack_ctrl_arb.sv
// Two-port round-robin arbiter: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);
    logic last_q;  // 1: port 1 was granted most recently

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/return_stack_ctrl.sv
// Return-stack controller: arbitrates CALL/RET and >R/R> ports, drives stack ops, flushes.
// Optional macro RSTACK_GUARD_EN suppresses overflowing PUSH / underflowing POP and sets ovf/unf.
module return_stack_ctrl
    import rstack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               CLK,
    input  logic               reset,
    return_stack_ctrl_if.slave bus,
    output state_t             state_dbg_o
);
    localparam logic [DEPTH_W-1:0] FULL_LVL = DEPTH_W'(DEPTH);

    state_t             state_q, state_d;
    op_t                op_q, stack_op;
    logic               win_q;
    logic [WIDTH-1:0]   w_q, rdata_q, w_out;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, unf_q, flush_pend_q;
    logic [1:0]         valid, grant, gnt, done;
    logic               accept, flush_req, full, empty, block_push, block_pop, flush_done;

    assign valid     = {bus.req1 && (bus.op1 != 2'd0), bus.req0 && (bus.op0 != 2'd0)};
    assign flush_req = bus.flush || flush_pend_q;
    assign accept    = (state_q == ST_IDLE) && !flush_req && (|valid);
    assign full      = (depth_q == FULL_LVL);
    assign empty     = (depth_q == '0);

`ifdef RSTACK_GUARD_EN
    assign block_push = (op_q == OP_PUSH) && full;
    assign block_pop  = (op_q == OP_POP) && empty;
`else
    assign block_push = 1'b0;
    assign block_pop  = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk_i   (CLK),
        .rst_i   (reset),
        .req_i   (valid),
        .accept_i(accept),
        .grant_o (grant)
    );

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        stack_op   = OP_NOP;
        w_out      = '0;
        gnt        = 2'b00;
        done       = 2'b00;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (|valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_DONE;
                gnt[win_q] = 1'b1;
                w_out      = w_q;
                if (!(block_push || block_pop)) begin
                    stack_op = op_q;
                end
                if (op_q == OP_PUSH && !full) begin
                    depth_d = depth_q + DEPTH_W'(1);
                end else if (op_q == OP_POP && !empty) begin
                    depth_d = depth_q - DEPTH_W'(1);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                done[win_q] = 1'b1;
            end
            ST_FLUSH: begin
                if (empty) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stack_op = OP_POP;
                    depth_d  = depth_q - DEPTH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset kills the in-flight op this very cycle, not one cycle later.
        if (reset) begin
            stack_op   = OP_NOP;
            gnt        = 2'b00;
            done       = 2'b00;
            flush_done = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            depth_q      <= '0;
            op_q         <= OP_NOP;
            win_q        <= 1'b0;
            w_q          <= '0;
            rdata_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            if (accept) begin
                win_q <= grant[1];
                op_q  <= op_t'(grant[1] ? bus.op1 : bus.op0);
                w_q   <= grant[1] ? bus.w1 : bus.w0;
            end
            if (state_q == ST_ISSUE) begin
                rdata_q <= bus.a;
                if (block_push) ovf_q <= 1'b1;
                if (block_pop)  unf_q <= 1'b1;
            end
            if (bus.flush && (state_q == ST_ISSUE || state_q == ST_DONE)) begin
                flush_pend_q <= 1'b1;
            end else if (state_q == ST_IDLE && flush_req) begin
                flush_pend_q <= 1'b0;
            end
        end
    end

    assign bus.gnt0       = gnt[0];
    assign bus.gnt1       = gnt[1];
    assign bus.done0      = done[0];
    assign bus.done1      = done[1];
    assign bus.rdata      = rdata_q;
    assign bus.flush_done = flush_done;
    assign bus.stackOP    = stack_op;
    assign bus.w          = w_out;
    assign bus.depth      = depth_q;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
    assign state_dbg_o    = state_q;

endmodule
